conv3x3_stream: RTL

Parametrised streaming 3×3 convolution engine, successor to the fixed 8-bit shift-register/arith/output-logic filter path. It accepts raster-order pixels over a valid/ready stream and keeps two internal line buffers, so the bus master no longer fetches three rows per window. Each output is a programmable signed 3×3 kernel sum, right-shifted and saturated with a clamp flag. It sits between the PCIe/Avalon read buffer and the write-back buffer.

---
 rtl/conv3x3_stream.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 convolution with two line buffers; optional CONV3X3_ABS_EN
module conv3x3_stream #(
  parameter int PIX_W    = 8,
  parameter int COEF_W   = 4,
  parameter int MAX_COLS = 1024
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                cfg_load,
  input  logic [15:0]         cfg_cols,
  input  logic [15:0]         cfg_rows,
  input  logic [9*COEF_W-1:0] cfg_coef,
  input  logic [3:0]          cfg_shift,
  input  logic                in_valid,
  input  logic [PIX_W-1:0]    in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [PIX_W-1:0]    out_data,
  output logic                out_sat,
  input  logic                out_ready,
  output logic                busy,
  output logic                frame_done,
  output logic                cfg_err
);

  localparam int SUM_W = PIX_W + COEF_W + 4;
  localparam int LB_AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam logic [16:0] MAX_COLS_L = 17'(MAX_COLS);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t state_q, state_d;
  logic [15:0] cols_q, cols_d, rows_q, rows_d;
  logic [9*COEF_W-1:0] coef_q, coef_d;
  logic [3:0] shift_q, shift_d;
  logic [15:0] col_q, col_d, row_q, row_d;
  logic cfg_err_q, cfg_err_d;

  logic [PIX_W-1:0] win_q [3][2];
  logic [PIX_W-1:0] win_d [3][2];
  logic [PIX_W-1:0] col_pix [3];
  logic [PIX_W-1:0] tap_pix [9];

  logic [PIX_W-1:0] lb0_q [MAX_COLS];
  logic [PIX_W-1:0] lb1_q [MAX_COLS];
  logic [LB_AW-1:0] lb_addr;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;

  logic s1_valid_q, s1_valid_d;
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic signed [SUM_W-1:0] sum_full, coef_ext, pix_ext;
  logic signed [SUM_W-1:0] shifted, mag, pix_max;
  logic [PIX_W-1:0] clamp_data;
  logic clamp_sat;

  logic out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic [PIX_W-1:0] out_data_q, out_data_d;

  logic adv, accept, cfg_ok, last_pix, win_hit;

  // Handshake and stage-advance control shared by the whole pipeline.
  always_comb begin
    adv      = !out_valid_q || out_ready;
    in_ready = (state_q == ST_RUN) && adv;
    accept   = in_valid && in_ready;
    cfg_ok   = (cfg_cols >= 16'd3) && (cfg_rows >= 16'd3) && ({1'b0, cfg_cols} <= MAX_COLS_L);
    last_pix = (col_q == cols_q - 16'd1) && (row_q == rows_q - 16'd1);
    win_hit  = accept && (row_q >= 16'd2) && (col_q >= 16'd2);
  end

  // Frame FSM: config latch/check, run until last pixel, drain until the pipe empties.
  always_comb begin
    state_d    = state_q;
    cols_d     = cols_q;
    rows_d     = rows_q;
    coef_d     = coef_q;
    shift_d    = shift_q;
    cfg_err_d  = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          if (cfg_ok) begin
            cols_d  = cfg_cols;
            rows_d  = cfg_rows;
            coef_d  = cfg_coef;
            shift_d = cfg_shift;
            state_d = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (accept && last_pix) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!s1_valid_q && !out_valid_q) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster position of the next pixel; cleared when a new frame is configured.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if ((state_q == ST_IDLE) && cfg_load && cfg_ok) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == cols_q - 16'd1) begin
        col_d = '0;
        row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  // Window assembly: two stored columns plus the column arriving with this pixel.
  always_comb begin
    lb_addr    = col_q[LB_AW-1:0];
    lb0_rd     = lb0_q[lb_addr];
    lb1_rd     = lb1_q[lb_addr];
    col_pix[0] = lb1_rd;
    col_pix[1] = lb0_rd;
    col_pix[2] = in_data;
    win_d      = win_q;
    for (int r = 0; r < 3; r++) begin
      tap_pix[3*r]   = win_q[r][0];
      tap_pix[3*r+1] = win_q[r][1];
      tap_pix[3*r+2] = col_pix[r];
      if (accept) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = col_pix[r];
      end
    end
  end

  // Stage 1: signed kernel sum over the completed window.
  always_comb begin
    sum_full = '0;
    coef_ext = '0;
    pix_ext  = '0;
    for (int k = 0; k < 9; k++) begin
      coef_ext = {{(SUM_W-COEF_W){coef_q[COEF_W*k+COEF_W-1]}}, coef_q[COEF_W*k +: COEF_W]};
      pix_ext  = {{(SUM_W-PIX_W){1'b0}}, tap_pix[k]};
      sum_full = sum_full + coef_ext * pix_ext;
    end
    s1_valid_d = s1_valid_q;
    sum_d      = sum_q;
    if (adv) begin
      s1_valid_d = win_hit;
      if (win_hit) sum_d = sum_full;
    end
  end

  // Stage 2: arithmetic shift, optional magnitude, clamp into the pixel range.
  always_comb begin
    shifted = sum_q >>> shift_q;
    mag     = shifted;
`ifdef CONV3X3_ABS_EN
    if (shifted[SUM_W-1]) mag = -shifted;
`endif
    pix_max    = {{(SUM_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};
    clamp_data = mag[PIX_W-1:0];
    clamp_sat  = 1'b0;
    if (mag[SUM_W-1]) begin
      clamp_data = '0;
      clamp_sat  = 1'b1;
    end else if (mag > pix_max) begin
      clamp_data = '1;
      clamp_sat  = 1'b1;
    end
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = clamp_data;
        out_sat_d  = clamp_sat;
      end
    end
  end

  // State, config, counters, window and pipeline registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      coef_q      <= '0;
      shift_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      cfg_err_q   <= 1'b0;
      s1_valid_q  <= 1'b0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= '0;
        win_q[r][1] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      coef_q      <= coef_d;
      shift_q     <= shift_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cfg_err_q   <= cfg_err_d;
      s1_valid_q  <= s1_valid_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      win_q       <= win_d;
    end
  end

  // Line buffers: each accepted pixel pushes its column down one row; never reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_q[lb_addr] <= lb0_rd;
      lb0_q[lb_addr] <= in_data;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign cfg_err   = cfg_err_q;

endmodule
